subneg_datapath: RTL and testbench

// Datapath for the SUBNEG one-instruction processor. It consumes the strobes from the

---
 rtl/subneg_datapath_if.sv | 36 +++
 rtl/subneg_datapath.sv | 86 ++++++++
 tb/tb_subneg_datapath.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/subneg_datapath_if.sv
// Strobe, program-load and observation bundle between the SUBNEG control side and its datapath.
// The master drives the strobes, the load port and the readback address. The slave reports state.
interface subneg_datapath_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              write_op1;
  logic              write_op2;
  logic              write_mem;
  logic              sel_pc;
  logic              write_pc;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [WIDTH-1:0]  load_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              neg;
  logic [ADDR_W-1:0] pc;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic              halted;

  modport master (
    output write_op1, write_op2, write_mem, sel_pc, write_pc,
    output load_en, load_addr, load_data, rd_addr,
    input  rd_data, neg, pc, op1, op2, halted
  );

  modport slave (
    input  write_op1, write_op2, write_mem, sel_pc, write_pc,
    input  load_en, load_addr, load_data, rd_addr,
    output rd_data, neg, pc, op1, op2, halted
  );
endinterface

// File: rtl/subneg_datapath.sv
// SUBNEG datapath: unified word memory, PC and operand registers driven by control strobes.
// Executes mem[b] <= mem[b] - mem[a]; branch to c on a negative result, else pc + 3.
module subneg_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  subneg_datapath_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WIDTH-1:0]  word_t;

  word_t mem_q [DEPTH];

  addr_t pc_q, pc_d;
  word_t op1_q, op1_d;
  word_t op2_q, op2_d;
  logic  neg_q, neg_d;
  logic  halted_q, halted_d;

  addr_t pc_p1, pc_p2, pc_p3;
  addr_t a_ptr, b_ptr, c_ptr;
  word_t diff;
  logic  mem_we;

  // Instruction fields are fetched combinationally through the current pc; addresses wrap.
  always_comb begin
    pc_p1 = pc_q + addr_t'(1);
    pc_p2 = pc_q + addr_t'(2);
    pc_p3 = pc_q + addr_t'(3);
    a_ptr = mem_q[pc_q][ADDR_W-1:0];
    b_ptr = mem_q[pc_p1][ADDR_W-1:0];
    c_ptr = mem_q[pc_p2][ADDR_W-1:0];
  end

  always_comb begin
    diff     = op2_q - op1_q;
    op1_d    = bus.write_op1 ? mem_q[a_ptr] : op1_q;
    op2_d    = bus.write_op2 ? mem_q[b_ptr] : op2_q;
    neg_d    = bus.write_mem ? diff[WIDTH-1] : neg_q;
    pc_d     = pc_q;
    if (bus.write_pc) begin
      pc_d = bus.sel_pc ? c_ptr : pc_p3;
    end
    halted_d = halted_q | (bus.write_pc & (pc_d == pc_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      neg_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      neg_q    <= neg_d;
      halted_q <= halted_d;
    end
  end

  // Reset abandons the in-flight instruction, but program loads stay live during reset.
  assign mem_we = bus.write_mem & ~rst;

  // Later assignment wins, so the subtraction result overrides a load to the same word.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
    if (mem_we) begin
      mem_q[b_ptr] <= diff;
    end
  end

  assign bus.rd_data = mem_q[bus.rd_addr];
  assign bus.neg     = neg_q;
  assign bus.pc      = pc_q;
  assign bus.op1     = op1_q;
  assign bus.op2     = op2_q;
  assign bus.halted  = halted_q;
endmodule

// File: tb/tb_subneg_datapath.sv
// Bench for subneg_datapath: table-driven program sequences, hand-written corner cases and a
// randomized run against an arithmetic reference model of the SUBNEG machine.
module tb_subneg_datapath;
  localparam logic [6:0] CRst = 7'h40;
  localparam logic [6:0] COp1 = 7'h20;
  localparam logic [6:0] COp2 = 7'h10;
  localparam logic [6:0] CMem = 7'h08;
  localparam logic [6:0] CSel = 7'h04;
  localparam logic [6:0] CWpc = 7'h02;
  localparam logic [6:0] CLd  = 7'h01;

  logic clk;
  logic rst;

  subneg_datapath_if #(.WIDTH(8), .DEPTH(16)) bus ();

  subneg_datapath #(.WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic [3:0] la;
    logic [7:0] ld;
    logic [3:0] ra;
    logic [3:0] e_pc;
    logic [7:0] e_op1;
    logic [7:0] e_op2;
    logic       e_neg;
    logic       e_halt;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, logic [6:0] ctl, logic [3:0] la, logic [7:0] ld,
                              logic [3:0] ra, logic [3:0] e_pc, logic [7:0] e_op1,
                              logic [7:0] e_op2, logic e_neg, logic e_halt, logic [7:0] e_rd);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.la = la; v.ld = ld; v.ra = ra;
    v.e_pc = e_pc; v.e_op1 = e_op1; v.e_op2 = e_op2;
    v.e_neg = e_neg; v.e_halt = e_halt; v.e_rd = e_rd;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(string nm, logic [3:0] e_pc, logic [7:0] e_op1, logic [7:0] e_op2,
                          logic e_neg, logic e_halt);
    chk({nm, " pc"}, 32'(bus.pc), 32'(e_pc));
    chk({nm, " op1"}, 32'(bus.op1), 32'(e_op1));
    chk({nm, " op2"}, 32'(bus.op2), 32'(e_op2));
    chk({nm, " neg"}, 32'(bus.neg), 32'(e_neg));
    chk({nm, " halted"}, 32'(bus.halted), 32'(e_halt));
  endtask

  task automatic chk_rd(string nm, logic [3:0] ra, logic [7:0] e_rd);
    bus.rd_addr = ra;
    #1;
    chk({nm, " rd_data"}, 32'(bus.rd_data), 32'(e_rd));
  endtask

  // One clock: apply strobes, take the edge, then release everything 1 time unit later.
  task automatic cyc(logic [6:0] ctl, logic [3:0] la, logic [7:0] d);
    rst           = ctl[6];
    bus.write_op1 = ctl[5];
    bus.write_op2 = ctl[4];
    bus.write_mem = ctl[3];
    bus.sel_pc    = ctl[2];
    bus.write_pc  = ctl[1];
    bus.load_en   = ctl[0];
    bus.load_addr = la;
    bus.load_data = d;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.write_op1 = 1'b0;
    bus.write_op2 = 1'b0;
    bus.write_mem = 1'b0;
    bus.sel_pc    = 1'b0;
    bus.write_pc  = 1'b0;
    bus.load_en   = 1'b0;
  endtask

  task automatic load(logic [3:0] a, logic [7:0] d);
    cyc(CLd, a, d);
  endtask

  // Reference model: the machine described as plain integer arithmetic on an array.
  int m_mem [16];
  int m_pc, m_op1, m_op2, m_neg, m_halt;

  task automatic model_step(logic [6:0] ctl, int la, int ld);
    int a, b, c, r, np;
    a = m_mem[m_pc] % 16;
    b = m_mem[(m_pc + 1) % 16] % 16;
    c = m_mem[(m_pc + 2) % 16] % 16;
    r = (m_op2 - m_op1) & 255;
    if (ctl[6]) begin
      m_pc = 0; m_op1 = 0; m_op2 = 0; m_neg = 0; m_halt = 0;
      if (ctl[0]) m_mem[la] = ld;
    end else begin
      np = ctl[2] ? c : (m_pc + 3) % 16;
      if (ctl[5]) m_op1 = m_mem[a];
      if (ctl[4]) m_op2 = m_mem[b];
      if (ctl[3]) m_neg = (r >= 128) ? 1 : 0;
      if (ctl[1]) begin
        if (np == m_pc) m_halt = 1;
        m_pc = np;
      end
      if (ctl[0]) m_mem[la] = ld;
      if (ctl[3]) m_mem[b] = r;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.write_op1 = 1'b0;
    bus.write_op2 = 1'b0;
    bus.write_mem = 1'b0;
    bus.sel_pc    = 1'b0;
    bus.write_pc  = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.rd_addr   = '0;

    // Reset with random strobes.
    for (int i = 0; i < 3; i++) begin
      cyc(CRst | 7'($urandom_range(0, 63) << 1), 4'd12, 8'h00);
      chk_regs("reset", 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    end

    // Branch taken: 3 - 5 = -2.
    add("A rst+ld0", CRst | CLd, 4'd0, 8'd6, 4'd0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd6);
    add("A ld1", CLd, 4'd1, 8'd7, 4'd1, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd7);
    add("A ld2", CLd, 4'd2, 8'd9, 4'd2, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd9);
    add("A ld6", CLd, 4'd6, 8'd5, 4'd6, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd5);
    add("A ld7", CLd, 4'd7, 8'd3, 4'd7, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd3);
    add("A op1", COp1, 4'd0, 8'd0, 4'd7, 4'd0, 8'd5, 8'd0, 1'b0, 1'b0, 8'd3);
    add("A op2", COp2, 4'd0, 8'd0, 4'd7, 4'd0, 8'd5, 8'd3, 1'b0, 1'b0, 8'd3);
    add("A mem", CMem, 4'd0, 8'd0, 4'd7, 4'd0, 8'd5, 8'd3, 1'b1, 1'b0, 8'hFE);
    add("A taken", CWpc | CSel, 4'd0, 8'd0, 4'd7, 4'd9, 8'd5, 8'd3, 1'b1, 1'b0, 8'hFE);
    // Not taken: 5 - 2 = 3; sel_pc alone must not move pc.
    add("B rst+ld6", CRst | CLd, 4'd6, 8'd2, 4'd6, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd2);
    add("B ld7", CLd, 4'd7, 8'd5, 4'd7, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd5);
    add("B op1+op2", COp1 | COp2, 4'd0, 8'd0, 4'd7, 4'd0, 8'd2, 8'd5, 1'b0, 1'b0, 8'd5);
    add("B mem", CMem, 4'd0, 8'd0, 4'd7, 4'd0, 8'd2, 8'd5, 1'b0, 1'b0, 8'd3);
    add("B not taken", CWpc, 4'd0, 8'd0, 4'd7, 4'd3, 8'd2, 8'd5, 1'b0, 1'b0, 8'd3);
    add("B sel only", CSel, 4'd0, 8'd0, 4'd7, 4'd3, 8'd2, 8'd5, 1'b0, 1'b0, 8'd3);
    // Equal operands, then same-cycle strobes sampling pre-edge state.
    add("C rst+ld6", CRst | CLd, 4'd6, 8'd4, 4'd6, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd4);
    add("C ld7", CLd, 4'd7, 8'd4, 4'd7, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd4);
    add("C op1+op2", COp1 | COp2, 4'd0, 8'd0, 4'd7, 4'd0, 8'd4, 8'd4, 1'b0, 1'b0, 8'd4);
    add("C mem equal", CMem, 4'd0, 8'd0, 4'd7, 4'd0, 8'd4, 8'd4, 1'b0, 1'b0, 8'd0);
    add("C ld6", CLd, 4'd6, 8'd9, 4'd6, 4'd0, 8'd4, 8'd4, 1'b0, 1'b0, 8'd9);
    add("C op1+ld6", COp1 | CLd, 4'd6, 8'd1, 4'd6, 4'd0, 8'd9, 8'd4, 1'b0, 1'b0, 8'd1);
    add("C mem+op1", CMem | COp1, 4'd0, 8'd0, 4'd7, 4'd0, 8'd1, 8'd4, 1'b1, 1'b0, 8'hFB);
    add("C op2", COp2, 4'd0, 8'd0, 4'd7, 4'd0, 8'd1, 8'hFB, 1'b1, 1'b0, 8'hFB);

    foreach (vecs[i]) begin
      cyc(vecs[i].ctl, vecs[i].la, vecs[i].ld);
      chk_regs(vecs[i].nm, vecs[i].e_pc, vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_neg,
               vecs[i].e_halt);
      chk_rd(vecs[i].nm, vecs[i].ra, vecs[i].e_rd);
    end

    // Wrap: instruction at 14 takes b from 15 and c from 0; pc+3 wraps to 1.
    cyc(CRst, 4'd0, 8'd0);
    load(4'd1, 8'h21);
    load(4'd2, 8'd14);
    cyc(CWpc | CSel, 4'd0, 8'd0);
    chk("wrap jump pc", 32'(bus.pc), 32'd14);
    load(4'd14, 8'd1);
    load(4'd15, 8'd2);
    load(4'd0, 8'd5);
    cyc(COp1 | COp2, 4'd0, 8'd0);
    chk_regs("wrap operands", 4'd14, 8'h21, 8'h0E, 1'b0, 1'b0);
    cyc(CMem, 4'd0, 8'd0);
    chk_rd("wrap result", 4'd2, 8'hED);
    chk("wrap neg", 32'(bus.neg), 32'd1);
    cyc(CWpc, 4'd0, 8'd0);
    chk("wrap pc+3", 32'(bus.pc), 32'd1);

    // Halt on branch-to-self, strobes still obeyed, then overflow wraps to positive.
    cyc(CRst, 4'd0, 8'd0);
    load(4'd2, 8'd9);
    load(4'd9, 8'd3);
    load(4'd10, 8'd4);
    load(4'd11, 8'd9);
    load(4'd3, 8'd5);
    load(4'd4, 8'd2);
    cyc(CWpc | CSel, 4'd0, 8'd0);
    chk_regs("halt jump", 4'd9, 8'd0, 8'd0, 1'b0, 1'b0);
    cyc(COp1 | COp2, 4'd0, 8'd0);
    cyc(CMem, 4'd0, 8'd0);
    chk_rd("halt result", 4'd4, 8'hFD);
    cyc(CWpc | CSel, 4'd0, 8'd0);
    chk_regs("halt self", 4'd9, 8'd5, 8'd2, 1'b1, 1'b1);
    load(4'd3, 8'd1);
    load(4'd4, 8'h80);
    cyc(COp1 | COp2, 4'd0, 8'd0);
    cyc(CMem, 4'd0, 8'd0);
    chk_regs("overflow", 4'd9, 8'd1, 8'h80, 1'b0, 1'b1);
    chk_rd("overflow result", 4'd4, 8'h7F);
    cyc(CWpc, 4'd0, 8'd0);
    chk_regs("halted sticky", 4'd12, 8'd1, 8'h80, 1'b0, 1'b1);
    cyc(CRst, 4'd0, 8'd0);
    chk_regs("halt reset", 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Collision: write_mem beats a load to the same word; other-address loads land.
    load(4'd0, 8'd3);
    load(4'd1, 8'd7);
    load(4'd3, 8'd2);
    load(4'd7, 8'd9);
    cyc(COp1 | COp2, 4'd0, 8'd0);
    cyc(CMem | CLd, 4'd7, 8'h55);
    chk_rd("collision same", 4'd7, 8'h07);
    cyc(CMem | CLd, 4'd5, 8'hAA);
    chk_rd("collision other", 4'd5, 8'hAA);
    chk_rd("collision other mem", 4'd7, 8'h07);

    // Randomized run against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [6:0] ctl;
      logic [7:0] d;
      ctl = (i == 0) ? (CRst | CLd) : CLd;
      d   = 8'($urandom_range(0, 255));
      model_step(ctl, i, int'(d));
      cyc(ctl, 4'(i), d);
    end
    for (int i = 0; i < 1500; i++) begin
      logic [6:0] ctl;
      logic [3:0] la;
      logic [3:0] ra;
      logic [7:0] d;
      ctl = {1'b0, 6'($urandom_range(0, 63))};
      ctl[0] = ($urandom_range(0, 3) == 0);
      ctl[6] = ($urandom_range(0, 63) == 0);
      la  = 4'($urandom_range(0, 15));
      d   = 8'($urandom_range(0, 255));
      ra  = 4'($urandom_range(0, 15));
      model_step(ctl, int'(la), int'(d));
      cyc(ctl, la, d);
      chk_regs("random", 4'(m_pc), 8'(m_op1), 8'(m_op2), m_neg[0], m_halt[0]);
      chk_rd("random", ra, 8'(m_mem[ra]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
